rs_issue_scheduler: RTL and testbench
=====================================

RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries arbitrated.
REQ-002 SHALL have parameter IDX_W, default $clog2(RS_SIZE), width of the entry index.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port in_entry_ready, input, RS_SIZE, bit i high means entry i is valid and both operands are ready.
REQ-006 SHALL have port in_fu_ready, input, 1, functional unit can accept an issue this cycle.
REQ-007 SHALL have port in_flush, input, 1, mispredict or exception flush.
REQ-008 SHALL have port out_issue_valid, output, 1, an entry is offered to the functional unit.
REQ-009 SHALL have port out_issue_idx, output, IDX_W, index of the offered entry.
REQ-010 SHALL have port out_entry_clear, output, RS_SIZE, one-hot entry-free strobe back to the reservation station.

Function
REQ-011 SHALL implement a 2-state FSM: IDLE (no offer) and OFFER (out_issue_valid=1).
REQ-012 SHALL, in IDLE with any in_entry_ready bit set and in_flush=0, select an entry and enter OFFER on the next edge; the latency from ready to offer is 1 cycle.
REQ-013 SHALL select round-robin: search starts at priority pointer ptr and ascends modulo RS_SIZE; the first set bit wins.
REQ-014 SHALL treat a handshake as accepted when out_issue_valid=1 and in_fu_ready=1 in the same cycle.
REQ-015 SHALL hold out_issue_valid and out_issue_idx stable in OFFER until accepted, even if in_entry_ready for that index drops.
REQ-016 SHALL drive out_entry_clear combinationally as onehot(out_issue_idx) in an accept cycle with in_flush=0, and zero in all other cycles.
REQ-017 SHALL, on accept, set ptr to (out_issue_idx+1) mod RS_SIZE; at index RS_SIZE-1 it wraps to 0.
REQ-018 SHALL, on accept, mask the accepted index from same-edge selection: if another ready bit is set, stay in OFFER with the new index (back-to-back issue, one per cycle), otherwise go to IDLE.
REQ-019 SHALL apply the search in REQ-018 starting at the updated ptr.
REQ-020 SHALL, when in_flush=1, force IDLE on the next edge and deassert out_issue_valid, with no out_entry_clear that cycle; flush takes priority over an accept and over new selection.
REQ-021 SHALL retain ptr across in_flush.
REQ-022 SHALL keep out_issue_valid=0 while in IDLE with in_entry_ready all-zero.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, set the state to IDLE, ptr to 0, out_issue_valid to 0 and out_issue_idx to 0; out_entry_clear is then 0.
REQ-024 SHALL abandon any pending offer on a reset mid-OFFER, with no clear strobe.
REQ-025 SHALL make its first selection after reset deassertion from a cycle with rst_n=1.

Configuration
REQ-026 SHALL, when RS_ISSUE_STATS_EN is defined, add 16-bit outputs out_issue_count (accepts) and out_stall_count (cycles in OFFER with in_fu_ready=0).
REQ-027 SHALL make both counters saturate at 16'hFFFF and reset to 0 with rst_n; they are not cleared by in_flush.
REQ-028 SHALL, when RS_ISSUE_STATS_EN is undefined, omit these ports and counters with no functional difference elsewhere.

Verification
REQ-029 SHALL cover: reset release, in_entry_ready=8'b0000_0100, in_fu_ready=1 -> next cycle valid=1, idx=2, clear=8'b0000_0100; ptr becomes 3.
REQ-030 SHALL cover: ready=8'b1000_0001 held, fu_ready=1, RS clears bits on the strobe -> idx 0 then 7 on consecutive cycles, then valid=0.
REQ-031 SHALL cover: offer idx=5 with fu_ready=0 for 3 cycles while ready[5] drops -> idx stays 5, valid=1, clear=0; accepted when fu_ready rises.
REQ-032 SHALL cover: ptr=7, ready=8'b1000_0001 -> idx 7 accepted, ptr wraps to 0, next offer idx 0.
REQ-033 SHALL cover: in_flush=1 in an accept cycle -> clear=0, valid=0 next cycle, ptr unchanged.
REQ-034 SHALL cover: with RS_ISSUE_STATS_EN defined, 4 accepts and 2 stall cycles -> issue_count=4, stall_count=2; rst_n=0 mid-OFFER -> both 0 and valid=0 next cycle.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Round-robin issue scheduler: picks one ready reservation-station entry per cycle and holds
// the offer until the functional unit accepts. Optional RS_ISSUE_STATS_EN adds accept/stall counters.
module rs_issue_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RS_SIZE-1:0] in_entry_ready,
  input  logic               in_fu_ready,
  input  logic               in_flush,
  output logic               out_issue_valid,
  output logic [IDX_W-1:0]   out_issue_idx,
  output logic [RS_SIZE-1:0] out_entry_clear
`ifdef RS_ISSUE_STATS_EN
  ,
  output logic [15:0]        out_issue_count,
  output logic [15:0]        out_stall_count
`endif
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   ptr_next;
  logic [RS_SIZE-1:0] idx_onehot;
  logic [RS_SIZE-1:0] masked_ready;
  logic               accept_eff;

  // First set bit of req searching upward from start, wrapping modulo RS_SIZE.
  function automatic logic [IDX_W-1:0] pick(input logic [RS_SIZE-1:0] req,
                                            input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0]   sel;
    logic [RS_SIZE-1:0] sh;
    int                 pos;
    sel = start;
    for (int k = RS_SIZE - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= RS_SIZE) pos = pos - RS_SIZE;
      sh = req >> pos;
      if (sh[0]) sel = IDX_W'(pos);
    end
    return sel;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_onehot
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign ptr_next        = (idx_reg == IDX_W'(RS_SIZE - 1)) ? '0 : idx_reg + 1'b1;
  assign masked_ready    = in_entry_ready & ~idx_onehot;
  // A reset or flush in the accept cycle abandons the entry, so no free strobe.
  assign accept_eff      = out_issue_valid & in_fu_ready & ~in_flush & rst_n;
  assign out_issue_valid = (state_reg == OFFER);
  assign out_issue_idx   = idx_reg;
  assign out_entry_clear = accept_eff ? idx_onehot : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
    end else if (in_flush) begin
      state_reg <= IDLE;
    end else if (state_reg == IDLE) begin
      if (|in_entry_ready) begin
        state_reg <= OFFER;
        idx_reg   <= pick(in_entry_ready, ptr_reg);
      end
    end else if (in_fu_ready) begin
      // Back-to-back issue: next pick excludes the entry just accepted.
      ptr_reg <= ptr_next;
      if (|masked_ready) begin
        idx_reg <= pick(masked_ready, ptr_next);
      end else begin
        state_reg <= IDLE;
      end
    end
  end

`ifdef RS_ISSUE_STATS_EN
  logic [15:0] issue_count_reg;
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if (accept_eff && issue_count_reg != 16'hFFFF)
        issue_count_reg <= issue_count_reg + 16'd1;
      if (out_issue_valid && !in_fu_ready && stall_count_reg != 16'hFFFF)
        stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign out_issue_count = issue_count_reg;
  assign out_stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Testbench for rs_issue_scheduler: directed scenarios plus randomized traffic against a
// behavioural round-robin model. Define RS_ISSUE_STATS_EN to also check the counters.
module tb_rs_issue_scheduler;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_entry_ready;
  logic         in_fu_ready;
  logic         in_flush;
  logic         out_issue_valid;
  logic [2:0]   out_issue_idx;
  logic [N-1:0] out_entry_clear;
`ifdef RS_ISSUE_STATS_EN
  logic [15:0]  out_issue_count;
  logic [15:0]  out_stall_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_issues;
  int m_stalls;

  rs_issue_scheduler #(.RS_SIZE(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_entry_ready  (in_entry_ready),
    .in_fu_ready     (in_fu_ready),
    .in_flush        (in_flush),
    .out_issue_valid (out_issue_valid),
    .out_issue_idx   (out_issue_idx),
    .out_entry_clear (out_entry_clear)
`ifdef RS_ISSUE_STATS_EN
    ,
    .out_issue_count (out_issue_count),
    .out_stall_count (out_stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_rr(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start + k) % N;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  // Compare DUT outputs against the model for the inputs currently applied.
  task automatic model_check(input string tag);
    logic [N-1:0] exp_clr;
    exp_clr = (m_valid && in_fu_ready && !in_flush && rst_n) ? N'(1 << m_idx) : '0;
    chk({tag, ".valid"}, 16'(out_issue_valid), 16'(m_valid));
    if (m_valid) chk({tag, ".idx"}, 16'(out_issue_idx), 16'(m_idx));
    chk({tag, ".clear"}, 16'(out_entry_clear), 16'(exp_clr));
`ifdef RS_ISSUE_STATS_EN
    chk({tag, ".issue_cnt"}, out_issue_count, 16'(m_issues));
    chk({tag, ".stall_cnt"}, out_stall_count, 16'(m_stalls));
`endif
    $display("cyc t=%0t %s rst_n=%0b rdy=%b fu=%0b fl=%0b -> valid=%0b idx=%0d clr=%b",
             $time, tag, rst_n, in_entry_ready, in_fu_ready, in_flush,
             out_issue_valid, out_issue_idx, out_entry_clear);
  endtask

  task automatic drive(input string tag, input logic r_n, input logic [N-1:0] rdy,
                       input logic fu, input logic fl);
    rst_n          = r_n;
    in_entry_ready = rdy;
    in_fu_ready    = fu;
    in_flush       = fl;
    #3;
    model_check(tag);
  endtask

  task automatic lit(input string tag, input logic v, input int i, input logic [N-1:0] c);
    chk({tag, ".lit_valid"}, 16'(out_issue_valid), 16'(v));
    if (v) chk({tag, ".lit_idx"}, 16'(out_issue_idx), 16'(i));
    chk({tag, ".lit_clear"}, 16'(out_entry_clear), 16'(c));
  endtask

  // Advance one clock and evolve the model from the inputs held across the edge.
  task automatic tick();
    logic [N-1:0] avail;
    int           pick;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_issues = 0; m_stalls = 0;
    end else begin
      if (m_valid && in_fu_ready && !in_flush && m_issues < 65535) m_issues++;
      if (m_valid && !in_fu_ready && m_stalls < 65535) m_stalls++;
      if (in_flush) begin
        m_valid = 0;
      end else if (!m_valid) begin
        pick = find_rr(in_entry_ready, m_ptr);
        if (pick >= 0) begin m_valid = 1; m_idx = pick; end
      end else if (in_fu_ready) begin
        m_ptr = (m_idx + 1) % N;
        avail = in_entry_ready;
        avail[m_idx] = 1'b0;
        pick = find_rr(avail, m_ptr);
        if (pick >= 0) m_idx = pick;
        else m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    m_valid = 0; m_idx = 0; m_ptr = 0; m_issues = 0; m_stalls = 0;
    rst_n = 1'b0; in_entry_ready = '0; in_fu_ready = 1'b0; in_flush = 1'b0;
    tick(); tick();

    // Reset state
    drive("reset", 1'b0, 8'h00, 1'b1, 1'b0); lit("reset", 1'b0, 0, 8'h00); tick();

    // Two ready entries drained back to back: idx 0 then 7
    drive("b2b.a", 1'b1, 8'h81, 1'b1, 1'b0); lit("b2b.a", 1'b0, 0, 8'h00); tick();
    drive("b2b.b", 1'b1, 8'h81, 1'b1, 1'b0); lit("b2b.b", 1'b1, 0, 8'h01); tick();
    drive("b2b.c", 1'b1, 8'h80, 1'b1, 1'b0); lit("b2b.c", 1'b1, 7, 8'h80); tick();
    drive("b2b.d", 1'b1, 8'h00, 1'b1, 1'b0); lit("b2b.d", 1'b0, 0, 8'h00); tick();

    // Single entry 2, one-cycle latency
    drive("one.a", 1'b1, 8'h04, 1'b1, 1'b0); lit("one.a", 1'b0, 0, 8'h00); tick();
    drive("one.b", 1'b1, 8'h00, 1'b1, 1'b0); lit("one.b", 1'b1, 2, 8'h04); tick();

    // Hold idx 5 through three stalls while its ready bit drops
    drive("hold.a", 1'b1, 8'h20, 1'b0, 1'b0); tick();
    drive("hold.b", 1'b1, 8'h20, 1'b0, 1'b0); lit("hold.b", 1'b1, 5, 8'h00); tick();
    drive("hold.c", 1'b1, 8'h00, 1'b0, 1'b0); lit("hold.c", 1'b1, 5, 8'h00); tick();
    drive("hold.d", 1'b1, 8'h00, 1'b0, 1'b0); lit("hold.d", 1'b1, 5, 8'h00); tick();
    drive("hold.e", 1'b1, 8'h00, 1'b1, 1'b0); lit("hold.e", 1'b1, 5, 8'h20); tick();

    // Move ptr to 7, then wrap 7 -> 0
    drive("wrap.a", 1'b1, 8'h40, 1'b1, 1'b0); tick();
    drive("wrap.b", 1'b1, 8'h00, 1'b1, 1'b0); lit("wrap.b", 1'b1, 6, 8'h40); tick();
    drive("wrap.c", 1'b1, 8'h81, 1'b1, 1'b0); tick();
    drive("wrap.d", 1'b1, 8'h81, 1'b1, 1'b0); lit("wrap.d", 1'b1, 7, 8'h80); tick();
    drive("wrap.e", 1'b1, 8'h01, 1'b1, 1'b0); lit("wrap.e", 1'b1, 0, 8'h01); tick();

    // Flush in an accept cycle, ptr stays at 1 (so pick 2 before 0)
    drive("flush.a", 1'b1, 8'h08, 1'b1, 1'b0); tick();
    drive("flush.b", 1'b1, 8'h08, 1'b1, 1'b1); lit("flush.b", 1'b1, 3, 8'h00); tick();
    drive("flush.c", 1'b1, 8'h00, 1'b1, 1'b0); lit("flush.c", 1'b0, 0, 8'h00); tick();
    drive("flush.d", 1'b1, 8'h05, 1'b1, 1'b0); tick();
    drive("flush.e", 1'b1, 8'h05, 1'b1, 1'b0); lit("flush.e", 1'b1, 2, 8'h04); tick();
    drive("flush.f", 1'b1, 8'h01, 1'b1, 1'b0); lit("flush.f", 1'b1, 0, 8'h01); tick();

    // Reset mid-OFFER with fu_ready high: no strobe, offer abandoned
    drive("rstmid.a", 1'b1, 8'h10, 1'b0, 1'b0); tick();
    drive("rstmid.b", 1'b0, 8'h10, 1'b1, 1'b0); lit("rstmid.b", 1'b1, 4, 8'h00); tick();
    drive("rstmid.c", 1'b1, 8'h00, 1'b0, 1'b0); lit("rstmid.c", 1'b0, 0, 8'h00);
`ifdef RS_ISSUE_STATS_EN
    chk("rstmid.issue0", out_issue_count, 16'd0);
    chk("rstmid.stall0", out_stall_count, 16'd0);
`endif
    tick();

    // Four accepts and two stall cycles
    drive("stat.a", 1'b1, 8'h0F, 1'b0, 1'b0); tick();
    drive("stat.b", 1'b1, 8'h0F, 1'b0, 1'b0); tick();
    drive("stat.c", 1'b1, 8'h0F, 1'b0, 1'b0); tick();
    drive("stat.d", 1'b1, 8'h0F, 1'b1, 1'b0); lit("stat.d", 1'b1, 0, 8'h01); tick();
    drive("stat.e", 1'b1, 8'h0E, 1'b1, 1'b0); lit("stat.e", 1'b1, 1, 8'h02); tick();
    drive("stat.f", 1'b1, 8'h0C, 1'b1, 1'b0); lit("stat.f", 1'b1, 2, 8'h04); tick();
    drive("stat.g", 1'b1, 8'h08, 1'b1, 1'b0); lit("stat.g", 1'b1, 3, 8'h08); tick();
    drive("stat.h", 1'b1, 8'h00, 1'b0, 1'b0); lit("stat.h", 1'b0, 0, 8'h00);
`ifdef RS_ISSUE_STATS_EN
    chk("stat.issue4", out_issue_count, 16'd4);
    chk("stat.stall2", out_stall_count, 16'd2);
`endif
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic r_n, fu, fl;
      logic [N-1:0] rdy;
      r_n = ($urandom_range(0, 49) != 0);
      fu  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      drive("rand", r_n, rdy, fu, fl);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
